// File: rtl/uart_loopback_if.sv
// rtl/uart_loopback_if.sv - serial pins plus the receiver-to-transmitter byte handshake
interface uart_loopback_if;
  logic       rxd;
  logic       txd;
  logic [7:0] dat;
  logic       stb;
  logic       rdy;

  modport master (input rxd, output txd, output dat, output stb, output rdy);
  modport slave  (output rxd, input txd, input dat, input stb, input rdy);
endinterface

// File: rtl/uart_loopback.sv
// rtl/uart_loopback.sv - 8N1 UART receiver feeding a transmitter; every good frame on rxd is echoed on txd
// dat/stb form a one-byte buffer so a new frame can arrive while the previous echo is still going out.
module uart_loopback #(
  parameter real BAUDRATE  = 9600.0,
  parameter real FREQUENCY = 12000000.0
) (
  input logic             clk,
  input logic             rst,
  uart_loopback_if.master bus
);

  localparam int CYCLES = $rtoi(FREQUENCY / BAUDRATE);
  localparam int HALF   = CYCLES / 2;
  localparam int CW     = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic          rxd_meta_q, rxd_sync_q;

  state_e        rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    dat_q;
  logic          stb_q;

  state_e        tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          txd_q;
  logic          rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= bus.rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Receiver: the START check at half a bit rejects glitches and aligns later samples to mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      dat_q      <= '0;
      stb_q      <= 1'b0;
    end else begin
      if (stb_q && rdy_q) begin
        stb_q <= 1'b0;
      end
      case (rx_state_q)
        S_IDLE: begin
          if (!rxd_sync_q) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rxd_sync_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == CYC_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= S_STOP;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == CYC_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            // A byte arriving while the buffer is still full is dropped, as is a bad stop bit.
            if (rxd_sync_q && !stb_q) begin
              dat_q <= rx_shift_q;
              stb_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rdy_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (stb_q && rdy_q) begin
            tx_shift_q <= dat_q;
            rdy_q      <= 1'b0;
            txd_q      <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == CYC_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == CYC_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              txd_q      <= tx_shift_q[1];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == CYC_LAST) begin
            tx_cnt_q   <= '0;
            rdy_q      <= 1'b1;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.txd = txd_q;
  assign bus.dat = dat_q;
  assign bus.stb = stb_q;
  assign bus.rdy = rdy_q;

endmodule

// File: tb/tb_uart_loopback.sv
// tb/tb_uart_loopback.sv - directed echo bench for uart_loopback at a reduced bit time of 32 clocks
module tb_uart_loopback;
  localparam int CYC  = 32;
  localparam int HALF = CYC / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  uart_loopback_if bus ();

  uart_loopback #(.BAUDRATE(375000.0), .FREQUENCY(12000000.0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [9:0] tx_q[$];
  logic       stb_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stb_prev <= 1'b0;
    end else begin
      if (bus.stb && !stb_prev) rx_q.push_back(bus.dat);
      stb_prev <= bus.stb;
    end
  end

  // Decodes txd as {stop, data, start}; a frame interrupted by reset is thrown away.
  always begin
    logic [9:0] fr;
    logic       aborted;
    @(negedge clk);
    if (!rst && bus.txd === 1'b0) begin
      aborted = 1'b0;
      fr = '0;
      for (int k = 1; k <= HALF + 9 * CYC; k++) begin
        @(negedge clk);
        if (rst) aborted = 1'b1;
        if (k >= HALF && ((k - HALF) % CYC) == 0) fr[(k - HALF) / CYC] = bus.txd;
      end
      if (!aborted) tx_q.push_back(fr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.rxd = v;
    repeat (CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    bus.rxd = 1'b1;
  endtask

  task automatic wait_tx(input string tag, input int n);
    int budget;
    budget = 40 * CYC;
    while (tx_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, tx_q.size(), n);
  endtask

  task automatic watch_idle(input int nclk, output int lows);
    lows = 0;
    for (int k = 0; k < nclk; k++) begin
      @(negedge clk);
      if (bus.txd !== 1'b1) lows++;
    end
  endtask

  task automatic check_tx(input string tag, input logic [7:0] b);
    if (tx_q.size() > 0) check(tag, tx_q.pop_front(), {1'b1, b, 1'b0});
    else check(tag, 32'hDEAD, {1'b1, b, 1'b0});
  endtask

  task automatic check_rx(input string tag, input logic [7:0] b);
    if (rx_q.size() > 0) check(tag, rx_q.pop_front(), b);
    else check(tag, 32'hDEAD, b);
  endtask

  initial begin
    int lows;
    int budget;
    bus.rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_txd", bus.txd, 1);
    check("rst_stb", bus.stb, 0);
    check("rst_dat", bus.dat, 8'h00);
    check("rst_rdy", bus.rdy, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(8'h8F, 1'b1);
    wait_tx("8f_count", 1);
    check_rx("8f_stb_dat", 8'h8F);
    check_tx("8f_echo", 8'h8F);
    repeat (2 * CYC) @(negedge clk);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_tx("b2b_count", 2);
    check_tx("b2b_first", 8'h00);
    check_tx("b2b_second", 8'hFF);
    check("b2b_rx_count", rx_q.size(), 2);
    rx_q.delete();
    repeat (2 * CYC) @(negedge clk);

    send_frame(8'h55, 1'b0);
    watch_idle(20 * CYC, lows);
    check("frame_err_txd", lows, 0);
    check("frame_err_stb", rx_q.size(), 0);

    bus.rxd = 1'b0;
    repeat (HALF - 4) @(negedge clk);
    bus.rxd = 1'b1;
    watch_idle(12 * CYC, lows);
    check("glitch_txd", lows, 0);
    check("glitch_stb", rx_q.size(), 0);

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    wait_tx("three_count", 3);
    check_tx("three_0", 8'h11);
    check_tx("three_1", 8'h22);
    check_tx("three_2", 8'h33);
    check("three_rx_count", rx_q.size(), 3);
    rx_q.delete();
    repeat (2 * CYC) @(negedge clk);

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b1;
    bus.rxd = 1'b1;
    @(negedge clk);
    check("rst_rx_txd", bus.txd, 1);
    check("rst_rx_stb", bus.stb, 0);
    check("rst_rx_rdy", bus.rdy, 1);
    rst = 1'b0;
    repeat (12 * CYC) @(negedge clk);
    check("rst_rx_no_echo", tx_q.size() + rx_q.size(), 0);

    send_frame(8'hA5, 1'b1);
    budget = 4 * CYC;
    while (bus.txd === 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("a5_tx_started", bus.txd, 0);
    repeat (4 * CYC) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_txd", bus.txd, 1);
    check("rst_tx_stb", bus.stb, 0);
    check("rst_tx_rdy", bus.rdy, 1);
    rst = 1'b0;
    repeat (12 * CYC) @(negedge clk);
    check("rst_tx_no_frame", tx_q.size(), 0);
    rx_q.delete();

    send_frame(8'h3C, 1'b1);
    wait_tx("3c_count", 1);
    check_rx("3c_stb_dat", 8'h3C);
    check_tx("3c_echo", 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
